// File: rtl/uart_imem_loader.sv
`default_nettype none
// ============================================================================
//  Module   : uart_imem_loader
//  Purpose  : Serial program loader for the CPU instruction RAM. Receives a
//             framed image over an 8N1 UART line, assembles big-endian 16-bit
//             words and writes them through a single-cycle write port. The
//             CPU is held in reset while a frame is in flight; the outcome of
//             each frame is reported as a done pulse or a sticky error flag.
//
//             Frame: 0xA5, N (0 => 2^ADDR_W words), 2N data bytes (high byte
//             first), checksum = modulo-256 sum of the data bytes.
//
//  Ports    : clk         system clock
//             rst         asynchronous active-high reset
//             rx          UART serial input, idle high, asynchronous to clk
//             imem_we     one-cycle write strobe to instruction RAM
//             imem_addr   write address, valid with imem_we
//             imem_wdata  write data, valid with imem_we
//             cpu_hold    high while a frame is being received
//             load_done   one-cycle pulse after a frame with a good checksum
//             load_err    sticky error; cleared by the next accepted header
//             word_count  words written by the last or current frame
//
//  Revision : 1.0  initial release
// ============================================================================
module uart_imem_loader #(
    parameter int CLKS_PER_BIT = 868,
    parameter int ADDR_W       = 8,
    parameter int TIMEOUT_BITS = 20
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              rx,
    output logic              imem_we,
    output logic [ADDR_W-1:0] imem_addr,
    output logic [15:0]       imem_wdata,
    output logic              cpu_hold,
    output logic              load_done,
    output logic              load_err,
    output logic [ADDR_W:0]   word_count
);

    // ------------------------------------------------------------------------
    // Constants
    // ------------------------------------------------------------------------
    localparam int c_CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [c_CNT_W-1:0] c_BIT_LAST  = c_CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [c_CNT_W-1:0] c_HALF_LAST = c_CNT_W'(CLKS_PER_BIT / 2 - 1);

    localparam int c_TO_LIMIT = TIMEOUT_BITS * CLKS_PER_BIT;
    localparam int c_TO_W     = $clog2(c_TO_LIMIT + 1);
    localparam logic [c_TO_W-1:0] c_TO_MAX = c_TO_W'(c_TO_LIMIT);

    // Wide enough for both the count byte and 2^ADDR_W.
    localparam int c_TGT_W = (ADDR_W + 1 > 9) ? ADDR_W + 1 : 9;
    localparam logic [c_TGT_W-1:0] c_FULL_IMAGE = c_TGT_W'(2 ** ADDR_W);

    localparam logic [7:0] c_HDR = 8'hA5;

    // ------------------------------------------------------------------------
    // rx synchronizer and falling-edge detect
    // ------------------------------------------------------------------------
    logic r_rx_meta;
    logic r_rx_sync;
    logic r_rx_prev;
    logic w_rx_fall;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rx_meta <= 1'b1;
            r_rx_sync <= 1'b1;
            r_rx_prev <= 1'b1;
        end else begin
            r_rx_meta <= rx;
            r_rx_sync <= r_rx_meta;
            r_rx_prev <= r_rx_sync;
        end
    end

    // An edge (rather than a low level) starts a byte, so a line stuck low
    // after a framing error does not retrigger reception.
    assign w_rx_fall = r_rx_prev & ~r_rx_sync;

    // ------------------------------------------------------------------------
    // Byte receiver
    // ------------------------------------------------------------------------
    typedef logic [1:0] rx_state_t;
    localparam rx_state_t c_RX_IDLE  = 2'd0;
    localparam rx_state_t c_RX_START = 2'd1;
    localparam rx_state_t c_RX_DATA  = 2'd2;
    localparam rx_state_t c_RX_STOP  = 2'd3;

    rx_state_t          r_rx_state;
    rx_state_t          w_rx_state_nxt;
    logic [c_CNT_W-1:0] r_rx_cnt;
    logic [c_CNT_W-1:0] w_rx_cnt_nxt;
    logic [2:0]         r_bit_idx;
    logic [2:0]         w_bit_idx_nxt;
    logic [7:0]         r_shift;
    logic [7:0]         w_shift_nxt;
    logic               r_byte_valid;
    logic               w_byte_valid_nxt;
    logic               r_frame_err;
    logic               w_frame_err_nxt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rx_state   <= c_RX_IDLE;
            r_rx_cnt     <= '0;
            r_bit_idx    <= '0;
            r_shift      <= '0;
            r_byte_valid <= 1'b0;
            r_frame_err  <= 1'b0;
        end else begin
            r_rx_state   <= w_rx_state_nxt;
            r_rx_cnt     <= w_rx_cnt_nxt;
            r_bit_idx    <= w_bit_idx_nxt;
            r_shift      <= w_shift_nxt;
            r_byte_valid <= w_byte_valid_nxt;
            r_frame_err  <= w_frame_err_nxt;
        end
    end

    always_comb begin
        w_rx_state_nxt   = r_rx_state;
        w_rx_cnt_nxt     = r_rx_cnt + c_CNT_W'(1);
        w_bit_idx_nxt    = r_bit_idx;
        w_shift_nxt      = r_shift;
        w_byte_valid_nxt = 1'b0;
        w_frame_err_nxt  = 1'b0;

        case (r_rx_state)
            c_RX_IDLE: begin
                w_rx_cnt_nxt = '0;
                if (w_rx_fall) begin
                    w_rx_state_nxt = c_RX_START;
                end
            end
            c_RX_START: begin
                // Mid start bit: a line already back high was a glitch.
                if (r_rx_cnt == c_HALF_LAST) begin
                    w_rx_cnt_nxt   = '0;
                    w_bit_idx_nxt  = '0;
                    w_rx_state_nxt = r_rx_sync ? c_RX_IDLE : c_RX_DATA;
                end
            end
            c_RX_DATA: begin
                if (r_rx_cnt == c_BIT_LAST) begin
                    w_rx_cnt_nxt  = '0;
                    w_shift_nxt   = {r_rx_sync, r_shift[7:1]};
                    w_bit_idx_nxt = r_bit_idx + 3'd1;
                    if (r_bit_idx == 3'd7) begin
                        w_rx_state_nxt = c_RX_STOP;
                    end
                end
            end
            c_RX_STOP: begin
                if (r_rx_cnt == c_BIT_LAST) begin
                    w_rx_cnt_nxt     = '0;
                    w_byte_valid_nxt = r_rx_sync;
                    w_frame_err_nxt  = ~r_rx_sync;
                    w_rx_state_nxt   = c_RX_IDLE;
                end
            end
            default: begin
                w_rx_state_nxt = c_RX_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------------
    // Loader FSM
    // ------------------------------------------------------------------------
    typedef logic [2:0] ld_state_t;
    localparam ld_state_t c_WAIT_HDR = 3'd0;
    localparam ld_state_t c_GET_CNT  = 3'd1;
    localparam ld_state_t c_GET_HI   = 3'd2;
    localparam ld_state_t c_GET_LO   = 3'd3;
    localparam ld_state_t c_GET_SUM  = 3'd4;

    ld_state_t          r_state;
    ld_state_t          w_state_nxt;
    logic [7:0]         r_n;
    logic [7:0]         w_n_nxt;
    logic [7:0]         r_hi;
    logic [7:0]         w_hi_nxt;
    logic [7:0]         r_sum;
    logic [7:0]         w_sum_nxt;
    logic [ADDR_W-1:0]  r_addr;
    logic [ADDR_W-1:0]  w_addr_nxt;
    logic [15:0]        r_wdata;
    logic [15:0]        w_wdata_nxt;
    logic               r_we;
    logic               w_we_nxt;
    logic               r_done;
    logic               w_done_nxt;
    logic               r_err;
    logic               w_err_nxt;
    logic               r_hold;
    logic               w_hold_nxt;
    logic [ADDR_W:0]    r_wc;
    logic [ADDR_W:0]    w_wc_nxt;
    logic [c_TO_W-1:0]  r_to_cnt;
    logic [c_TO_W-1:0]  w_to_cnt_nxt;

    logic               w_timeout;
    logic [c_TGT_W-1:0] w_target;
    logic [ADDR_W:0]    w_wc_inc;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state  <= c_WAIT_HDR;
            r_n      <= '0;
            r_hi     <= '0;
            r_sum    <= '0;
            r_addr   <= '0;
            r_wdata  <= '0;
            r_we     <= 1'b0;
            r_done   <= 1'b0;
            r_err    <= 1'b0;
            r_hold   <= 1'b0;
            r_wc     <= '0;
            r_to_cnt <= '0;
        end else begin
            r_state  <= w_state_nxt;
            r_n      <= w_n_nxt;
            r_hi     <= w_hi_nxt;
            r_sum    <= w_sum_nxt;
            r_addr   <= w_addr_nxt;
            r_wdata  <= w_wdata_nxt;
            r_we     <= w_we_nxt;
            r_done   <= w_done_nxt;
            r_err    <= w_err_nxt;
            r_hold   <= w_hold_nxt;
            r_wc     <= w_wc_nxt;
            r_to_cnt <= w_to_cnt_nxt;
        end
    end

    // A count byte of zero stands for a full 2^ADDR_W-word image.
    assign w_target  = (r_n == 8'd0) ? c_FULL_IMAGE : c_TGT_W'(r_n);
    assign w_wc_inc  = r_wc + (ADDR_W + 1)'(1);
    assign w_timeout = (r_state != c_WAIT_HDR) && (r_to_cnt == c_TO_MAX);

    always_comb begin
        w_state_nxt = r_state;
        w_n_nxt     = r_n;
        w_hi_nxt    = r_hi;
        w_sum_nxt   = r_sum;
        // The address advances in the cycle after each strobe so that it is
        // stable alongside imem_we.
        w_addr_nxt  = r_we ? (r_addr + ADDR_W'(1)) : r_addr;
        w_wdata_nxt = r_wdata;
        w_we_nxt    = 1'b0;
        w_done_nxt  = 1'b0;
        w_err_nxt   = r_err;
        w_hold_nxt  = r_hold;
        w_wc_nxt    = r_wc;

        // Idle-gap counter: cleared by every byte, frozen at the limit.
        if ((r_state == c_WAIT_HDR) || r_byte_valid) begin
            w_to_cnt_nxt = '0;
        end else if (w_timeout) begin
            w_to_cnt_nxt = r_to_cnt;
        end else begin
            w_to_cnt_nxt = r_to_cnt + c_TO_W'(1);
        end

        // A byte arriving on the timeout cycle wins over the timeout.
        if (r_byte_valid) begin
            case (r_state)
                c_WAIT_HDR: begin
                    if (r_shift == c_HDR) begin
                        w_hold_nxt  = 1'b1;
                        w_err_nxt   = 1'b0;
                        w_wc_nxt    = '0;
                        w_addr_nxt  = '0;
                        w_sum_nxt   = '0;
                        w_state_nxt = c_GET_CNT;
                    end
                end
                c_GET_CNT: begin
                    w_n_nxt     = r_shift;
                    w_state_nxt = c_GET_HI;
                end
                c_GET_HI: begin
                    w_hi_nxt    = r_shift;
                    w_sum_nxt   = r_sum + r_shift;
                    w_state_nxt = c_GET_LO;
                end
                c_GET_LO: begin
                    w_wdata_nxt = {r_hi, r_shift};
                    w_we_nxt    = 1'b1;
                    w_sum_nxt   = r_sum + r_shift;
                    w_wc_nxt    = w_wc_inc;
                    w_state_nxt = (c_TGT_W'(w_wc_inc) == w_target) ? c_GET_SUM : c_GET_HI;
                end
                c_GET_SUM: begin
                    if (r_shift == r_sum) begin
                        w_done_nxt = 1'b1;
                    end else begin
                        w_err_nxt = 1'b1;
                    end
                    w_hold_nxt  = 1'b0;
                    w_state_nxt = c_WAIT_HDR;
                end
                default: begin
                    w_state_nxt = c_WAIT_HDR;
                end
            endcase
        end else if ((r_frame_err && (r_state != c_WAIT_HDR)) || w_timeout) begin
            // Abort; words already written are left in RAM.
            w_err_nxt   = 1'b1;
            w_hold_nxt  = 1'b0;
            w_state_nxt = c_WAIT_HDR;
        end
    end

    // ------------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------------
    assign imem_we    = r_we;
    assign imem_addr  = r_addr;
    assign imem_wdata = r_wdata;
    assign cpu_hold   = r_hold;
    assign load_done  = r_done;
    assign load_err   = r_err;
    assign word_count = r_wc;

endmodule
`default_nettype wire

// File: tb/tb_uart_imem_loader.sv
`default_nettype none
// ============================================================================
//  Module   : tb_uart_imem_loader
//  Purpose  : Scoreboard testbench for uart_imem_loader. Byte streams are fed
//             to a frame-level reference model that queues the expected RAM
//             writes and frame outcomes; a monitor compares them against the
//             DUT whenever it strobes a write or reports an outcome.
//  Revision : 1.0  initial release
// ============================================================================
module tb_uart_imem_loader;

    localparam int CLKS_PER_BIT = 16;
    localparam int ADDR_W       = 8;
    localparam int TIMEOUT_BITS = 20;

    logic              clk = 1'b0;
    logic              rst;
    logic              rx;
    logic              imem_we;
    logic [ADDR_W-1:0] imem_addr;
    logic [15:0]       imem_wdata;
    logic              cpu_hold;
    logic              load_done;
    logic              load_err;
    logic [ADDR_W:0]   word_count;

    always #5 clk = ~clk;

    uart_imem_loader #(
        .CLKS_PER_BIT (CLKS_PER_BIT),
        .ADDR_W       (ADDR_W),
        .TIMEOUT_BITS (TIMEOUT_BITS)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .rx         (rx),
        .imem_we    (imem_we),
        .imem_addr  (imem_addr),
        .imem_wdata (imem_wdata),
        .cpu_hold   (cpu_hold),
        .load_done  (load_done),
        .load_err   (load_err),
        .word_count (word_count)
    );

    typedef struct {
        logic [ADDR_W-1:0] addr;
        logic [15:0]       data;
    } wr_t;

    typedef struct {
        bit err;
        int wc;
    } ev_t;

    wr_t        exp_wr[$];
    ev_t        exp_ev[$];
    logic [7:0] stim[$];
    int         n_checks = 0;
    int         n_pass   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ------------------------------------------------------------------------
    // Reference model: walks a byte stream frame by frame. Bytes outside a
    // frame other than 0xA5 are skipped. A frame cut short produces an error
    // outcome only when the stream is known to end in an abort.
    // ------------------------------------------------------------------------
    task automatic model(input bit aborted);
        int  i;
        int  n;
        int  wc;
        int  sum;
        wr_t w;
        ev_t e;
        i = 0;
        while (i < stim.size()) begin
            if (stim[i] != 8'hA5) begin
                i++;
            end else if (i + 1 >= stim.size()) begin
                if (aborted) begin
                    e.err = 1'b1;
                    e.wc  = 0;
                    exp_ev.push_back(e);
                end
                i = stim.size();
            end else begin
                n   = (stim[i+1] == 8'd0) ? (1 << ADDR_W) : int'(stim[i+1]);
                i   = i + 2;
                wc  = 0;
                sum = 0;
                while ((wc < n) && (i + 1 < stim.size())) begin
                    w.addr = ADDR_W'(wc % (1 << ADDR_W));
                    w.data = {stim[i], stim[i+1]};
                    exp_wr.push_back(w);
                    sum = (sum + int'(stim[i]) + int'(stim[i+1])) % 256;
                    wc++;
                    i = i + 2;
                end
                if ((wc == n) && (i < stim.size())) begin
                    e.err = (int'(stim[i]) != sum);
                    e.wc  = wc;
                    exp_ev.push_back(e);
                    i++;
                end else begin
                    if (aborted) begin
                        e.err = 1'b1;
                        e.wc  = wc;
                        exp_ev.push_back(e);
                    end
                    i = stim.size();
                end
            end
        end
    endtask

    // ------------------------------------------------------------------------
    // Monitor
    // ------------------------------------------------------------------------
    initial begin : monitor
        wr_t w;
        ev_t e;
        bit  err_prev;
        err_prev = 1'b0;
        forever begin
            @(negedge clk);
            if (rst) begin
                err_prev = 1'b0;
            end else begin
                if (imem_we) begin
                    check("write_expected", 32'(exp_wr.size() != 0), 32'd1);
                    if (exp_wr.size() != 0) begin
                        w = exp_wr.pop_front();
                        check("write_addr", 32'(imem_addr), 32'(w.addr));
                        check("write_data", 32'(imem_wdata), 32'(w.data));
                    end
                end
                if (load_done || (load_err && !err_prev)) begin
                    check("event_expected", 32'(exp_ev.size() != 0), 32'd1);
                    if (exp_ev.size() != 0) begin
                        e = exp_ev.pop_front();
                        check("event_kind {err,done}", 32'({load_err, load_done}),
                              e.err ? 32'd2 : 32'd1);
                        check("event_word_count", 32'(word_count), 32'(e.wc));
                        check("event_cpu_hold_low", 32'(cpu_hold), 32'd0);
                    end
                end
                err_prev = load_err;
            end
        end
    end

    // ------------------------------------------------------------------------
    // Stimulus helpers (driven on the falling edge)
    // ------------------------------------------------------------------------
    task automatic bit_time(input logic v);
        rx = v;
        repeat (CLKS_PER_BIT) @(negedge clk);
    endtask

    task automatic idle_bits(input int n);
        rx = 1'b1;
        repeat (n * CLKS_PER_BIT) @(negedge clk);
    endtask

    task automatic send_byte(input logic [7:0] b, input logic stop);
        bit_time(1'b0);
        for (int k = 0; k < 8; k++) bit_time(b[k]);
        bit_time(stop);
        rx = 1'b1;
    endtask

    // Loads n bytes, most significant first, into the stimulus queue.
    task automatic load_stim(input logic [63:0] bytes, input int n);
        stim.delete();
        for (int k = n - 1; k >= 0; k--) stim.push_back(bytes[8*k +: 8]);
    endtask

    task automatic send_stim(input bit aborted);
        model(aborted);
        foreach (stim[k]) begin
            send_byte(stim[k], 1'b1);
            idle_bits($urandom_range(0, 3));
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_imem_we"},    32'(imem_we),    32'd0);
        check({tag, "_imem_addr"},  32'(imem_addr),  32'd0);
        check({tag, "_imem_wdata"}, 32'(imem_wdata), 32'd0);
        check({tag, "_cpu_hold"},   32'(cpu_hold),   32'd0);
        check({tag, "_load_done"},  32'(load_done),  32'd0);
        check({tag, "_load_err"},   32'(load_err),   32'd0);
        check({tag, "_word_count"}, 32'(word_count), 32'd0);
    endtask

    initial begin : watchdog
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    // ------------------------------------------------------------------------
    // Stimulus
    // ------------------------------------------------------------------------
    initial begin : stimulus
        rst = 1'b1;
        rx  = 1'b1;
        repeat (4) @(negedge clk);
        check_reset_outputs("reset");
        rst = 1'b0;
        idle_bits(2);

        // Good two-word frame with cpu_hold tracked byte by byte.
        load_stim(64'hA5_02_95_C9_96_CA_BE, 7);
        model(1'b0);
        foreach (stim[k]) begin
            send_byte(stim[k], 1'b1);
            if (k == 0) check("hold_after_header", 32'(cpu_hold), 32'd1);
            if (k == 5) check("hold_before_sum",   32'(cpu_hold), 32'd1);
        end
        idle_bits(1);
        check("good_hold_low",   32'(cpu_hold),   32'd0);
        check("good_err_low",    32'(load_err),   32'd0);
        check("good_word_count", 32'(word_count), 32'd2);

        // Same frame, bad checksum.
        load_stim(64'hA5_02_95_C9_96_CA_BF, 7);
        send_stim(1'b0);
        check("badsum_err",  32'(load_err), 32'd1);
        check("badsum_hold", 32'(cpu_hold), 32'd0);

        // Leading non-header bytes are ignored.
        load_stim(64'h00_FF_12_A5_01_12_34_46, 8);
        send_stim(1'b0);
        check("junk_err", 32'(load_err), 32'd0);

        // Short low glitch: no byte, no error.
        rx = 1'b0;
        repeat (CLKS_PER_BIT / 4) @(negedge clk);
        idle_bits(3);
        check("glitch_err",  32'(load_err), 32'd0);
        check("glitch_hold", 32'(cpu_hold), 32'd0);

        // Randomized frames, some with header values inside the data and
        // some with a corrupted checksum.
        for (int f = 0; f < 6; f++) begin
            int         n;
            int         j;
            logic [7:0] b;
            logic [7:0] sum;
            stim.delete();
            j = $urandom_range(0, 2);
            for (int k = 0; k < j; k++) begin
                b = 8'($urandom_range(0, 255));
                if (b == 8'hA5) b = 8'h5A;
                stim.push_back(b);
            end
            n = $urandom_range(1, 5);
            stim.push_back(8'hA5);
            stim.push_back(8'(n));
            sum = 8'd0;
            for (int k = 0; k < 2 * n; k++) begin
                b = ($urandom_range(0, 3) == 0) ? 8'hA5 : 8'($urandom_range(0, 255));
                stim.push_back(b);
                sum = sum + b;
            end
            if ($urandom_range(0, 2) == 0) sum = sum ^ 8'h01;
            stim.push_back(sum);
            send_stim(1'b0);
        end

        // Inter-byte timeout after one word of a three-word frame.
        load_stim(64'hA5_03_11_22, 4);
        send_stim(1'b1);
        idle_bits(21);
        check("timeout_err",  32'(load_err), 32'd1);
        check("timeout_hold", 32'(cpu_hold), 32'd0);

        // Framing error while waiting for a high byte.
        load_stim(64'hA5_02, 2);
        send_stim(1'b1);
        send_byte(8'h33, 1'b0);
        idle_bits(2);
        check("framing_err",  32'(load_err), 32'd1);
        check("framing_hold", 32'(cpu_hold), 32'd0);

        // Reset in the middle of a four-word frame (after a high byte).
        load_stim(64'hA5_04_11_22_33_44_55, 7);
        send_stim(1'b0);
        #2;
        rst = 1'b1;
        #1;
        check_reset_outputs("midrst");
        repeat (3) @(negedge clk);
        rst = 1'b0;
        idle_bits(2);

        // Fresh one-word frame after reset loads to address 0.
        load_stim(64'hA5_01_AB_CD_78, 5);
        send_stim(1'b0);
        idle_bits(2);
        check("post_reset_word_count", 32'(word_count), 32'd1);

        check("writes_all_seen", 32'(exp_wr.size()), 32'd0);
        check("events_all_seen", 32'(exp_ev.size()), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
